// File: rtl/tdc_encoder_ctrl.sv
// Sequencer and readout buffer for the TDC encoder: aligns to the bunch-crossing frame,
// generates the encoder write strobes, and queues tagged hit words in a FWFT FIFO.
module tdc_encoder_ctrl #(
   parameter int ENC_PHASE = 4,
   parameter int CAP_PHASE = 6,
   parameter int FIFO_AW   = 3,
   parameter int CNT_W     = 8
) (
   input  logic             clk320M,
   input  logic             rst,
   input  logic             enable,
   input  logic             bcSync,
   input  logic             clrErr,
   input  logic [9:0]       TOA_codeReg,
   input  logic [8:0]       TOT_codeReg,
   input  logic [9:0]       Cal_codeReg,
   input  logic             hitFlag,
   input  logic             TOAerrorFlagReg,
   input  logic             TOTerrorFlagReg,
   input  logic             CalerrorFlagReg,
   output logic             RawdataWrtClk,
   output logic             EncdataWrtClk,
   output logic             ResetFlag,
   input  logic             rdEn,
   output logic [39:0]      dataOut,
   output logic             empty,
   output logic             full,
   output logic [CNT_W-1:0] errCnt,
   output logic [CNT_W-1:0] ovfCnt,
   output logic             syncErr,
   output logic             running
);

   typedef enum logic [1:0] {IDLE, ARMED, RUN} state_e;

   localparam logic [2:0]       ENC_PH   = 3'(ENC_PHASE);
   localparam logic [2:0]       CAP_PH   = 3'(CAP_PHASE);
   localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};

   state_e           state_q, state_d;
   logic [2:0]       phase_q, phase_d;
   logic [7:0]       bcid_q, bcid_d;
   logic             sync_err_q, sync_err_d;
   logic             raw_q, raw_d;
   logic             enc_q, enc_d;
   logic [2:0]       enc_rel;
   logic [CNT_W-1:0] err_cnt_q, ovf_cnt_q;
   logic [3:0]       rf_cnt_q;

   logic [39:0]        mem [2**FIFO_AW];
   logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [FIFO_AW:0]   count_q;
   logic               cap, push, pop_ok, push_ok, drop, any_err;
   logic [39:0]        wdata;

   // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latches).
   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      bcid_d     = bcid_q;
      sync_err_d = sync_err_q;
      unique case (state_q)
         IDLE: begin
            phase_d = 3'd0;
            if (enable) state_d = ARMED;
         end
         ARMED: begin
            if (!enable) begin
               state_d = IDLE;
            end else if (bcSync) begin
               state_d = RUN;
               phase_d = 3'd0;
               bcid_d  = 8'd0;
            end
         end
         RUN: begin
            if (phase_q == 3'd7 && !enable) begin
               state_d = IDLE;
               phase_d = 3'd0;
            end else if (bcSync) begin
               phase_d = 3'd0;
               bcid_d  = bcid_q + 8'd1;
               if (phase_q != 3'd7) sync_err_d = 1'b1;
            end else begin
               phase_d = phase_q + 3'd1;
               if (phase_q == 3'd7) bcid_d = bcid_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (clrErr) sync_err_d = 1'b0;

      // Strobes are registered from next-state phase so they line up with phase_q.
      enc_rel = phase_d - ENC_PH;
      raw_d   = (state_d == RUN) && (phase_d < 3'd4);
      enc_d   = (state_d == RUN) && (enc_rel < 3'd4);
   end

   assign cap     = (state_q == RUN) && (phase_q == CAP_PH);
   assign push    = cap && hitFlag;
   assign any_err = TOAerrorFlagReg | TOTerrorFlagReg | CalerrorFlagReg;
   assign pop_ok  = rdEn && (count_q != '0);
   assign push_ok = push && ((count_q != FULL_CNT) || pop_ok);
   assign drop    = push && !push_ok;
   assign wdata   = {bcid_q, TOAerrorFlagReg, TOTerrorFlagReg, CalerrorFlagReg,
                     TOA_codeReg, TOT_codeReg, Cal_codeReg};

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk320M) begin
      if (rst) begin
         state_q    <= IDLE;
         phase_q    <= 3'd0;
         bcid_q     <= 8'd0;
         sync_err_q <= 1'b0;
         raw_q      <= 1'b0;
         enc_q      <= 1'b0;
         err_cnt_q  <= '0;
         ovf_cnt_q  <= '0;
         rf_cnt_q   <= 4'd0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         bcid_q     <= bcid_d;
         sync_err_q <= sync_err_d;
         raw_q      <= raw_d;
         enc_q      <= enc_d;

         if (clrErr)                               err_cnt_q <= '0;
         else if (cap && any_err && err_cnt_q != '1) err_cnt_q <= err_cnt_q + CNT_W'(1);

         if (clrErr)                         ovf_cnt_q <= '0;
         else if (drop && ovf_cnt_q != '1)   ovf_cnt_q <= ovf_cnt_q + CNT_W'(1);

         if (clrErr)                rf_cnt_q <= 4'd8;
         else if (rf_cnt_q != 4'd0) rf_cnt_q <= rf_cnt_q - 4'd1;

         if (push_ok) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
         unique case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + (FIFO_AW+1)'(1);
            2'b01:   count_q <= count_q - (FIFO_AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // NOTE: the storage array is not reset; flushing the pointers is enough to discard its contents.
   always_ff @(posedge clk320M) begin
      if (push_ok) mem[wr_ptr_q] <= wdata;
   end

   assign empty         = (count_q == '0);
   assign full          = (count_q == FULL_CNT);
   assign dataOut       = empty ? 40'd0 : mem[rd_ptr_q];
   assign RawdataWrtClk = raw_q;
   assign EncdataWrtClk = enc_q;
   assign ResetFlag     = (rf_cnt_q != 4'd0);
   assign errCnt        = err_cnt_q;
   assign ovfCnt        = ovf_cnt_q;
   assign syncErr       = sync_err_q;
   assign running       = (state_q == RUN);

endmodule

// File: tb/tb_tdc_encoder_ctrl.sv
// Directed self-checking bench for tdc_encoder_ctrl: frame strobes, capture, FIFO limits,
// resync, error counting, ResetFlag window, and mid-frame reset.
module tb_tdc_encoder_ctrl;

   logic        clk320M = 1'b0;
   logic        rst, enable, bcSync, clrErr, hitFlag, rdEn;
   logic        TOAerrorFlagReg, TOTerrorFlagReg, CalerrorFlagReg;
   logic [9:0]  TOA_codeReg, Cal_codeReg;
   logic [8:0]  TOT_codeReg;
   logic        RawdataWrtClk, EncdataWrtClk, ResetFlag, empty, full, syncErr, running;
   logic [39:0] dataOut;
   logic [7:0]  errCnt, ovfCnt;

   int total = 0;
   int bad   = 0;

   always #2 clk320M = ~clk320M;

   tdc_encoder_ctrl dut (
      .clk320M(clk320M), .rst(rst), .enable(enable), .bcSync(bcSync), .clrErr(clrErr),
      .TOA_codeReg(TOA_codeReg), .TOT_codeReg(TOT_codeReg), .Cal_codeReg(Cal_codeReg),
      .hitFlag(hitFlag), .TOAerrorFlagReg(TOAerrorFlagReg), .TOTerrorFlagReg(TOTerrorFlagReg),
      .CalerrorFlagReg(CalerrorFlagReg), .RawdataWrtClk(RawdataWrtClk),
      .EncdataWrtClk(EncdataWrtClk), .ResetFlag(ResetFlag), .rdEn(rdEn), .dataOut(dataOut),
      .empty(empty), .full(full), .errCnt(errCnt), .ovfCnt(ovfCnt), .syncErr(syncErr),
      .running(running)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk320M);
   endtask

   function automatic logic [39:0] expw(input logic [7:0] b, input logic [2:0] e);
      return {b, e, 10'h155, 9'h0AA, 10'h2AA};
   endfunction

   task automatic do_reset();
      rst = 1'b1; enable = 1'b0; bcSync = 1'b0; clrErr = 1'b0; hitFlag = 1'b0; rdEn = 1'b0;
      TOAerrorFlagReg = 1'b0; TOTerrorFlagReg = 1'b0; CalerrorFlagReg = 1'b0;
      tick(2);
      rst = 1'b0;
   endtask

   // Leaves the DUT in RUN at phase 0, bcid 0.
   task automatic start_run();
      enable = 1'b1;
      tick(1);
      bcSync = 1'b1;
      tick(1);
      bcSync = 1'b0;
   endtask

   initial begin
      TOA_codeReg = 10'h155; TOT_codeReg = 9'h0AA; Cal_codeReg = 10'h2AA;
      do_reset();
      check("rst_running", running, 0);
      check("rst_raw", RawdataWrtClk, 0);
      check("rst_enc", EncdataWrtClk, 0);
      check("rst_rflag", ResetFlag, 0);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_cnts", {errCnt, ovfCnt, 7'd0, syncErr}, 0);
      check("rst_data", dataOut, 0);

      // T1: strobe pattern and first capture
      hitFlag = 1'b1;
      enable  = 1'b1;
      tick(1);
      check("t1_armed_not_run", running, 0);
      bcSync = 1'b1;
      tick(1);
      bcSync = 1'b0;
      check("t1_running", running, 1);
      for (int p = 0; p < 8; p++) begin
         check($sformatf("t1_raw_p%0d", p), RawdataWrtClk, (p < 4) ? 1 : 0);
         check($sformatf("t1_enc_p%0d", p), EncdataWrtClk, (p >= 4) ? 1 : 0);
         if (p == 6) check("t1_empty_before_cap", empty, 1);
         if (p != 7) tick(1);
      end
      check("t1_empty_after_cap", empty, 0);
      check("t1_word0", dataOut, expw(8'd0, 3'b000));
      rdEn = 1'b1;
      tick(1);
      rdEn = 1'b0;
      check("t1_popped", empty, 1);
      tick(7);
      check("t1_word1", dataOut, expw(8'd1, 3'b000));

      // T2: fill, overflow, simultaneous push/pop while full, drain order
      do_reset();
      hitFlag = 1'b1;
      start_run();
      tick(55);
      check("t2_not_full_7", full, 0);
      tick(8);
      check("t2_full_8", full, 1);
      check("t2_ovf0", ovfCnt, 0);
      tick(16);
      check("t2_ovf2", ovfCnt, 2);
      check("t2_still_full", full, 1);
      tick(7);
      check("t2_head0", dataOut, expw(8'd0, 3'b000));
      rdEn = 1'b1;
      tick(1);
      rdEn = 1'b0;
      check("t2_pushpop_full", full, 1);
      check("t2_pushpop_ovf", ovfCnt, 2);
      hitFlag = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         check($sformatf("t2_pop%0d", i), dataOut, expw((i < 8) ? 8'(i) : 8'd10, 3'b000));
         rdEn = 1'b1;
         tick(1);
      end
      rdEn = 1'b0;
      check("t2_drained", empty, 1);

      // T3: on-phase resync is clean, off-phase resync is flagged
      do_reset();
      start_run();
      tick(7);
      bcSync = 1'b1;
      tick(1);
      bcSync = 1'b0;
      check("t3_onphase_nosync", syncErr, 0);
      tick(3);
      bcSync = 1'b1;
      tick(1);
      bcSync = 1'b0;
      check("t3_syncerr", syncErr, 1);
      check("t3_enc_ph0", EncdataWrtClk, 0);
      check("t3_raw_ph0", RawdataWrtClk, 1);
      hitFlag = 1'b1;
      tick(6);
      check("t3_empty_ph6", empty, 1);
      tick(1);
      check("t3_word_bcid2", dataOut, expw(8'd2, 3'b000));
      clrErr = 1'b1;
      tick(1);
      clrErr = 1'b0;
      check("t3_syncerr_clr", syncErr, 0);
      check("t3_rflag", ResetFlag, 1);

      // T4: error counting, clrErr, ResetFlag window and restart
      do_reset();
      TOTerrorFlagReg = 1'b1;
      hitFlag = 1'b1;
      start_run();
      tick(6);
      check("t4_err_ph6", errCnt, 0);
      tick(1);
      check("t4_err_ph7", errCnt, 1);
      check("t4_word_toterr", dataOut, expw(8'd0, 3'b010));
      tick(17);
      check("t4_err3", errCnt, 3);
      TOTerrorFlagReg = 1'b0;
      hitFlag = 1'b0;
      tick(8);
      check("t4_err_hold", errCnt, 3);
      clrErr = 1'b1;
      tick(1);
      clrErr = 1'b0;
      check("t4_err_clr", errCnt, 0);
      check("t4_rf_1", ResetFlag, 1);
      for (int i = 2; i <= 8; i++) begin
         tick(1);
         check($sformatf("t4_rf_%0d", i), ResetFlag, 1);
      end
      tick(1);
      check("t4_rf_end", ResetFlag, 0);
      clrErr = 1'b1;
      tick(1);
      clrErr = 1'b0;
      tick(3);
      clrErr = 1'b1;
      tick(1);
      clrErr = 1'b0;
      for (int i = 2; i <= 8; i++) begin
         tick(1);
         check($sformatf("t4_rfre_%0d", i), ResetFlag, 1);
      end
      tick(1);
      check("t4_rfre_end", ResetFlag, 0);

      // T5: enable drop mid-frame completes the frame, re-enable waits for bcSync
      do_reset();
      start_run();
      tick(2);
      enable = 1'b0;
      for (int p = 2; p < 8; p++) begin
         check($sformatf("t5_run_p%0d", p), running, 1);
         check($sformatf("t5_raw_p%0d", p), RawdataWrtClk, (p < 4) ? 1 : 0);
         check($sformatf("t5_enc_p%0d", p), EncdataWrtClk, (p >= 4) ? 1 : 0);
         tick(1);
      end
      check("t5_idle", running, 0);
      check("t5_strobes_off", {RawdataWrtClk, EncdataWrtClk}, 0);
      enable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         check($sformatf("t5_armed_quiet_%0d", i), {running, RawdataWrtClk, EncdataWrtClk}, 0);
      end
      bcSync = 1'b1;
      tick(1);
      bcSync = 1'b0;
      check("t5_rerun", running, 1);
      check("t5_rerun_raw", RawdataWrtClk, 1);

      // T6: reset mid-frame with data queued
      do_reset();
      TOAerrorFlagReg = 1'b1;
      hitFlag = 1'b1;
      start_run();
      tick(37);
      check("t6_pre_err", errCnt, 4);
      check("t6_pre_enc", EncdataWrtClk, 1);
      check("t6_pre_word3", dataOut, expw(8'd0, 3'b100));
      rst = 1'b1;
      tick(1);
      check("t6_empty", empty, 1);
      check("t6_cnts", {errCnt, ovfCnt, 7'd0, syncErr}, 0);
      check("t6_idle", running, 0);
      check("t6_strobes", {RawdataWrtClk, EncdataWrtClk}, 0);
      check("t6_data", dataOut, 0);
      rst = 1'b0; enable = 1'b0; hitFlag = 1'b0; TOAerrorFlagReg = 1'b0;
      clrErr = 1'b1;
      tick(1);
      clrErr = 1'b0;
      check("t6_rf_idle", ResetFlag, 1);
      check("t6_still_idle", running, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
